uc_multiciclo: RTL and testbench

- Multicycle MIPS control unit; replaces the single-cycle opcode decoder for the shared-memory datapath.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over 3–5+ cycles.
- Holds in memory states on a ready/valid memory handshake, with timeout.
- Traps on illegal opcodes.
- Sits between the IR opcode field and the datapath muxes, register-file write enable and memory interface.

---
 rtl/uc_multiciclo.sv | 173 +++++++++++++++++
 tb/tb_uc_multiciclo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle MIPS control unit (Moore FSM with memory handshake, timeout and illegal-opcode trap)
module uc_multiciclo #(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 3,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic               bus_err,
  output logic               instr_done,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC_R = 4'd6, S_RWB = 4'd7,
    S_BRANCH = 4'd8, S_EXEC_I = 4'd9, S_IWB = 4'd10, S_JUMP = 4'd11,
    S_TRAP = 4'd12, S_BUSERR = 4'd13
  } state_t;
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SP2  = OP_W'(6'b011100);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b101);
  state_t r_state, w_nxt;
  logic [TMO_W-1:0] r_cnt;
  logic r_illegal, r_buserr;
  logic w_wait, w_tmo, w_itype;
  assign w_wait  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_tmo   = w_wait && !mem_ready && (r_cnt == TMO_W'(MEM_TIMEOUT - 1));
  assign w_itype = (OP == OP_ADDI) || (OP == OP_ANDI) || (OP == OP_ORI) || (OP == OP_SLTI);
  assign state      = r_state;
  assign illegal_op = r_illegal;
  assign bus_err    = r_buserr;
  // state register, wait counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= (w_wait && !mem_ready) ? r_cnt + 1'b1 : '0;
      r_illegal <= r_illegal | (w_nxt == S_TRAP);
      r_buserr  <= r_buserr | (w_nxt == S_BUSERR);
    end
  end
  // next-state sequencing; a timeout overrides the hold in a wait state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_FETCH:  w_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_nxt = (OP == OP_LW || OP == OP_SW) ? S_MEMADR :
                        (OP == OP_R || OP == OP_SP2) ? S_EXEC_R :
                        (OP == OP_BEQ)               ? S_BRANCH :
                        (OP == OP_J)                 ? S_JUMP   :
                        w_itype                      ? S_EXEC_I : S_TRAP;
      S_MEMADR: w_nxt = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R: w_nxt = S_RWB;
      S_EXEC_I: w_nxt = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: w_nxt = S_FETCH;
      default:  w_nxt = r_state;
    endcase
    if (w_tmo) w_nxt = S_BUSERR;
  end
  // Moore output decode; only handshake strobes look at mem_ready
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FN;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        instr_done  = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (OP == OP_ANDI) ? ALU_AND :
                  (OP == OP_ORI)  ? ALU_OR  :
                  (OP == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: scoreboard bench for the multicycle control unit
module tb_uc_multiciclo;
  logic clk, rst_n, mem_ready;
  logic [5:0] OP;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOp;
  logic illegal_op, bus_err, instr_done;
  logic [3:0] state;
  int n_pass = 0, n_total = 0, n_done = 0;
  logic [23:0] q[$];

  uc_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .bus_err(bus_err), .instr_done(instr_done),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // expected output word for a state, built from the control table
  function automatic logic [23:0] model(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, done;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, done} = '0;
    sb = 2'b00;
    ps = 2'b00;
    ao = 3'b000;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mw = 1; iord = 1; done = rdy; end
      4'd6:  begin sa = 1; ao = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin sa = 1; ao = 3'b001; pcwc = 1; ps = 2'b01; done = 1; end
      4'd9:  begin
        sa = 1;
        sb = 2'b10;
        ao = (op == 6'b001100) ? 3'b101 : (op == 6'b001101) ? 3'b011 : (op == 6'b001010) ? 3'b100 : 3'b000;
      end
      4'd10: begin rw = 1; done = 1; end
      4'd11: begin pcw = 1; ps = 2'b10; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ao, st == 4'd12, st == 4'd13, done, st};
  endfunction

  function automatic logic [23:0] observed();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
            ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op, bus_err, instr_done, state};
  endfunction

  // one clock in expected state est: drive, push expectation, compare on the falling edge
  task automatic cyc(input logic rdy, input logic [3:0] est, input string nm);
    logic [23:0] exp_v, got;
    mem_ready = rdy;
    q.push_back(model(est, OP, rdy));
    @(negedge clk);
    exp_v = q.pop_front();
    got = observed();
    n_total++;
    if (got !== exp_v) $display("FAIL %s: state=%0d got=%h expected=%h", nm, state, got, exp_v);
    else n_pass++;
    if (instr_done === 1'b1) n_done++;
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset asserted between edges; FETCH decode must appear with no clock
  task automatic do_reset(input string nm);
    logic [23:0] exp_v, got;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    q.push_back(model(4'd0, OP, 1'b0));
    #2;
    exp_v = q.pop_front();
    got = observed();
    n_total++;
    if (got !== exp_v) $display("FAIL %s: got=%h expected=%h", nm, got, exp_v);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    OP = 6'b100011;
    do_reset("reset");
    cyc(1'b1, 4'd0, "reset_fetch");
    cyc(1'b1, 4'd1, "reset_decode");
    do_reset("reset_again");
  endtask

  task automatic test_lw();
    int d0;
    OP = 6'b100011;
    d0 = n_done;
    cyc(1'b1, 4'd0, "lw_fetch");
    cyc(1'b1, 4'd1, "lw_decode");
    cyc(1'b1, 4'd2, "lw_memadr");
    cyc(1'b1, 4'd3, "lw_memrd");
    cyc(1'b1, 4'd4, "lw_memwb");
    n_total++;
    if (n_done - d0 != 1) $display("FAIL lw_done_count: got=%0d expected=1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_sw();
    int d0;
    OP = 6'b101011;
    d0 = n_done;
    cyc(1'b1, 4'd0, "sw_fetch");
    cyc(1'b1, 4'd1, "sw_decode");
    cyc(1'b0, 4'd2, "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd5, "sw_wait");
    cyc(1'b1, 4'd5, "sw_write");
    n_total++;
    if (n_done - d0 != 1) $display("FAIL sw_done_count: got=%0d expected=1", n_done - d0);
    else n_pass++;
  endtask

  // register/immediate/branch/jump instructions; s3=0 marks a 3-cycle instruction
  task automatic instr(input logic [5:0] op, input logic [3:0] s2, input logic [3:0] s3, input string nm);
    OP = op;
    cyc(1'b1, 4'd0, nm);
    cyc(1'($urandom_range(1)), 4'd1, nm);
    cyc(1'($urandom_range(1)), s2, nm);
    if (s3 != 4'd0) cyc(1'($urandom_range(1)), s3, nm);
  endtask

  task automatic test_back_to_back();
    instr(6'b001100, 4'd9, 4'd10, "andi");
    instr(6'b000000, 4'd6, 4'd7, "rtype");
    instr(6'b000100, 4'd8, 4'd0, "beq");
    instr(6'b001000, 4'd9, 4'd10, "addi");
    instr(6'b001101, 4'd9, 4'd10, "ori");
    instr(6'b001010, 4'd9, 4'd10, "slti");
    instr(6'b011100, 4'd6, 4'd7, "special2");
    instr(6'b000010, 4'd11, 4'd0, "jump");
  endtask

  task automatic test_abort();
    OP = 6'b001000;
    cyc(1'b1, 4'd0, "abort_fetch");
    cyc(1'b1, 4'd1, "abort_decode");
    cyc(1'b1, 4'd9, "abort_exec");
    do_reset("abort_reset");
    cyc(1'b0, 4'd0, "abort_after");
  endtask

  task automatic test_trap();
    OP = 6'b111111;
    cyc(1'b1, 4'd0, "trap_fetch");
    cyc(1'b1, 4'd1, "trap_decode");
    for (int i = 0; i < 20; i++) cyc(1'($urandom_range(1)), 4'd12, "trap_hold");
    do_reset("trap_reset");
  endtask

  task automatic test_timeout();
    OP = 6'b100011;
    for (int i = 0; i < 15; i++) cyc(1'b0, 4'd0, "tmo_fetch_wait");
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd13, "tmo_buserr");
    do_reset("tmo_reset");
    for (int i = 0; i < 14; i++) cyc(1'b0, 4'd0, "tmo_edge_wait");
    cyc(1'b1, 4'd0, "tmo_edge_ready");
    cyc(1'b0, 4'd1, "tmo_edge_decode");
    cyc(1'b0, 4'd2, "tmo_edge_memadr");
    for (int i = 0; i < 15; i++) cyc(1'b0, 4'd3, "tmo_memrd_wait");
    cyc(1'b1, 4'd13, "tmo_memrd_buserr");
    do_reset("tmo_reset2");
    cyc(1'b1, 4'd0, "tmo_clear_fetch");
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    OP = 6'b0;
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_abort();
    test_trap();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
